des_serial_tx: RTL and testbench
================================

Name: des_serial_tx

Overview:
- Output-side serializer; sits directly downstream of the DES core.
- Accepts one 64-bit ciphertext block over a valid/ready handshake.
- Shifts the block out MSB-first, one bit per sclk, with a frame strobe and an end-of-block pulse.
- Mirror of the serial input path: the external link sees 64 contiguous bits per block.

Parameters:
- BLOCK_W, 64, width of the parallel block and number of bits shifted per frame.
- CNT_W, 7, bit counter width; must satisfy 2**CNT_W > BLOCK_W.

Ports:
- sclk  input  1  serial/system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- blk_in  input  BLOCK_W  block to transmit; sampled only on accept.
- blk_valid  input  1  blk_in holds a valid block.
- blk_ready  output  1  block can be accepted this cycle.
- data_out  output  1  serial bit, registered.
- frame_out  output  1  high while data_out carries a valid bit.
- done_out  output  1  one-cycle pulse in the cycle carrying the last bit of a frame.

Behaviour:
- Reset: synchronous, active-high. When rst is high at a rising edge:
  - state=IDLE, shift register=0, counter=0;
  - data_out=0, frame_out=0, done_out=0, blk_ready=1 (next cycle onward).
  - Reset mid-frame aborts the frame immediately; no further bits are driven, and the partial frame is not resumed.
- Accept: the rising edge where blk_valid && blk_ready == 1. blk_in is latched into the shift register and the counter is cleared.
- States:
  - IDLE: blk_ready=1, frame_out=0. On accept -> SHIFT.
  - SHIFT: frame_out=1, data_out = shift_reg[BLOCK_W-1]. Each edge shifts left by 1, filling with 0, and increments the counter.
  - LAST: entered when the counter reaches BLOCK_W-1. Drives the final bit with done_out=1 and blk_ready=1.
    - Accept in LAST -> SHIFT with the new block; back-to-back frames with no gap.
    - No accept in LAST -> IDLE.
- Latency: accept at edge T -> bit 63 (MSB) on data_out during cycle T+1 -> bit 0 during cycle T+BLOCK_W. done_out is high in that final cycle only.
- blk_ready is combinational from state: high in IDLE and LAST, low in SHIFT.
- blk_valid is ignored while blk_ready=0. The upstream stage holds blk_in/blk_valid until accepted; no data loss.
- Counter:
  - counts 0..BLOCK_W-1 and never wraps past BLOCK_W-1;
  - clears to 0 on every accept;
  - holds in IDLE.
- Simultaneous rst and accept: rst wins; the block is dropped.
- data_out=0 whenever frame_out=0.

Optional Feature:
- Macro: DES_TX_PARITY_EN.
- Defined:
  - one extra bit is appended after bit 0: odd parity over the 64 block bits, so the total count of ones across 65 bits is odd;
  - frame_out stays high for BLOCK_W+1 cycles;
  - done_out and the LAST state move to the parity cycle;
  - the counter terminal value becomes BLOCK_W.
- Undefined: exactly BLOCK_W bits per frame, no parity logic.

Decomposition:
- Package des_io_pkg:
  - localparam BLOCK_W=64;
  - typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_LAST} tx_state_t;
  - function odd_parity64.
- Sub-module tx_bit_counter:
  - synchronous active-high reset;
  - inputs: clear, count_enable, terminal value;
  - outputs: count and terminal flag;
  - instantiated once.

Test Plan:
- Reset, then blk_in=64'h8000_0000_0000_0001 with valid -> data_out sequence 1, then 62 zeros, then 1; frame_out high 64 cycles; done_out high only in cycle 64.
- Back-to-back: present 64'hFFFF_FFFF_FFFF_FFFF, then 64'h0 with valid held -> 128 contiguous frame_out cycles; first 64 bits=1, next 64=0; two done_out pulses exactly 64 cycles apart.
- blk_valid pulsed during SHIFT -> ignored; blk_ready=0; no corruption of the current frame (check 64'h0123_4567_89AB_CDEF shifts out exactly).
- Assert rst at bit 20 of frame 64'hA5A5_A5A5_A5A5_A5A5 -> next cycle frame_out=0, data_out=0, blk_ready=1; a new block then transmits fully.
- With DES_TX_PARITY_EN, blk_in=64'h0000_0000_0000_0003 -> 65 bits, last bit=1 (odd parity); blk_in=64'h1 -> last bit=0; done_out on bit 65.
- blk_valid held low for 200 cycles after reset -> frame_out, data_out, done_out stay 0; blk_ready stays 1.

Source files
------------

// File: rtl/des_io_pkg.sv
// Shared types and helpers for the DES serial I/O path.
package des_io_pkg;

  localparam int BLOCK_W = 64;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_LAST
  } tx_state_t;

  // Returns the bit that makes the total number of ones (data plus parity) odd.
  function automatic logic odd_parity64(input logic [63:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Saturating bit counter for the serial transmitter; flags the step onto the terminal value.
module tx_bit_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             term_next
);

  // term_next is high on the edge that moves the count onto the terminal value.
  assign term_next = count_enable && (count == terminal - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_enable && (count != terminal)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/des_serial_tx.sv
// MSB-first serializer for 64-bit DES ciphertext blocks with frame and end-of-block strobes.
// Define DES_TX_PARITY_EN to append an odd-parity bit after bit 0 of every frame.
module des_serial_tx #(
  parameter int BLOCK_W = des_io_pkg::BLOCK_W,
  parameter int CNT_W   = 7
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic               blk_valid,
  output logic               blk_ready,
  output logic               data_out,
  output logic               frame_out,
  output logic               done_out
);
  import des_io_pkg::*;

`ifdef DES_TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SR_W     = BLOCK_W + PAR_W;
  localparam int LAST_IDX = SR_W - 1;

  tx_state_t        state;
  logic [SR_W-1:0]  shift_reg;
  logic [SR_W-1:0]  load_word;
  logic [CNT_W-1:0] bit_count;
  logic             term_next;
  logic             accept;

  // Handshake: a block transfers on any rising edge where blk_valid and blk_ready
  // are both high; blk_ready depends only on state, so it never looks at blk_valid.
  assign blk_ready = (state != TX_SHIFT);
  assign accept    = blk_valid && blk_ready;

`ifdef DES_TX_PARITY_EN
  assign load_word = {blk_in, odd_parity64(64'(blk_in))};
`else
  assign load_word = blk_in;
`endif

  tx_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk          (sclk),
    .rst          (rst),
    .clear        (accept),
    .count_enable (state == TX_SHIFT),
    .terminal     (CNT_W'(LAST_IDX)),
    .count        (bit_count),
    .term_next    (term_next)
  );

  // The first bit is driven straight from the accepted word, so the register
  // only needs to hold the bits still to come.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= TX_IDLE;
      shift_reg <= '0;
      data_out  <= 1'b0;
      frame_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      unique case (state)
        TX_SHIFT: begin
          data_out  <= shift_reg[SR_W-1];
          shift_reg <= shift_reg << 1;
          frame_out <= 1'b1;
          if (term_next) begin
            state    <= TX_LAST;
            done_out <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state     <= TX_SHIFT;
            shift_reg <= load_word << 1;
            data_out  <= load_word[SR_W-1];
            frame_out <= 1'b1;
            done_out  <= 1'b0;
          end else begin
            state     <= TX_IDLE;
            data_out  <= 1'b0;
            frame_out <= 1'b0;
            done_out  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst) begin
      assert (bit_count <= CNT_W'(LAST_IDX));
    end
  end

endmodule

// File: tb/tb_des_serial_tx.sv
// Bench for des_serial_tx: vector table, hand sequences and random frames against a cycle queue model.
module tb_des_serial_tx;

  localparam int BLOCK_W = 64;
`ifdef DES_TX_PARITY_EN
  localparam int FRAME_LEN = BLOCK_W + 1;
`else
  localparam int FRAME_LEN = BLOCK_W;
`endif

  // clock / reset
  logic               sclk = 1'b0;
  logic               rst = 1'b1;
  logic [BLOCK_W-1:0] blk_in = '0;
  logic               blk_valid = 1'b0;
  logic               blk_ready;
  logic               data_out;
  logic               frame_out;
  logic               done_out;

  always #5 sclk = ~sclk;

  des_serial_tx dut (
    .sclk      (sclk),
    .rst       (rst),
    .blk_in    (blk_in),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .data_out  (data_out),
    .frame_out (frame_out),
    .done_out  (done_out)
  );

  // scoreboard: one {data, frame, done} entry per future output cycle
  logic [2:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;
  bit         last_acc;
  logic [64:0] cap_word;
  int         cap_len;
  int         done_at;

  typedef struct {
    logic [63:0] blk;
    logic [63:0] exp_word;
    logic        exp_par;
    bit          noise;
  } vec_t;

  vec_t vecs[8];

  function automatic logic par_of(input logic [63:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  function automatic logic frame_bit(input logic [63:0] b, input int i);
    if (i < BLOCK_W) return b[BLOCK_W-1-i];
    return par_of(b);
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // driver: one clock edge, model update from the inputs at that edge, then compare
  task automatic step();
    logic [2:0] e;
    @(posedge sclk);
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else if (blk_valid && exp_q.size() == 0) begin
      last_acc = 1'b1;
      for (int i = 0; i < FRAME_LEN; i++)
        exp_q.push_back({frame_bit(blk_in, i), 1'b1, (i == FRAME_LEN - 1)});
    end
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    check("outputs", 65'({data_out, frame_out, done_out}), 65'(e));
    check("blk_ready", 65'(blk_ready), 65'(exp_q.size() == 0));
    if (last_acc) begin
      cap_word = '0;
      cap_len  = 0;
      done_at  = 0;
    end
    if (frame_out) begin
      cap_word = {cap_word[63:0], data_out};
      cap_len++;
      if (done_out) done_at = cap_len;
    end
  endtask

  task automatic start_frame(input logic [63:0] b);
    bit got = 1'b0;
    blk_in    = b;
    blk_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    blk_valid = 1'b0;
    blk_in    = {$urandom, $urandom};
    if (!got) timeout_fail("accept");
  endtask

  task automatic finish_frame(input bit noise);
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
      if (noise) begin
        blk_valid = 1'($urandom_range(0, 1));
        blk_in    = {$urandom, $urandom};
      end
      step();
    end
    blk_valid = 1'b0;
    if (exp_q.size() > 0) timeout_fail("frame_end");
  endtask

  task automatic run_vec(input vec_t v, input string name);
    start_frame(v.blk);
    finish_frame(v.noise);
`ifdef DES_TX_PARITY_EN
    check({name, "_word"}, 65'(cap_word[64:1]), 65'(v.exp_word));
    check({name, "_parity"}, 65'(cap_word[0]), 65'(v.exp_par));
`else
    check({name, "_word"}, 65'(cap_word[63:0]), 65'(v.exp_word));
`endif
    check({name, "_len"}, 65'(cap_len), 65'(FRAME_LEN));
    check({name, "_done_pos"}, 65'(done_at), 65'(FRAME_LEN));
  endtask

  initial begin
    logic        b_q[$];
    int          done_idx[$];
    int          bad;
    logic [63:0] rb;
    vec_t        rv;

    vecs[0] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 1'b0};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, 1'b1, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b0, 1'b1};
    vecs[6] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_frame", 65'(frame_out), 65'(0));
    check("reset_data", 65'(data_out), 65'(0));
    check("reset_done", 65'(done_out), 65'(0));
    check("reset_ready", 65'(blk_ready), 65'(1));

    // idle with valid low
    for (int k = 0; k < 200; k++) begin
      blk_in = {$urandom, $urandom};
      step();
    end
    blk_in = '0;

    // vector table
    for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // back-to-back frames with valid held
    b_q.delete();
    done_idx.delete();
    start_frame(64'hFFFF_FFFF_FFFF_FFFF);
    b_q.push_back(data_out);
    blk_in    = 64'h0;
    blk_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (last_acc) blk_valid = 1'b0;
      if (!frame_out) break;
      b_q.push_back(data_out);
      if (done_out) done_idx.push_back(b_q.size() - 1);
    end
    blk_valid = 1'b0;
    check("b2b_len", 65'(b_q.size()), 65'(2 * FRAME_LEN));
    bad = 0;
    for (int i = 0; i < b_q.size() && i < 2 * FRAME_LEN; i++) begin
      if (i < FRAME_LEN) begin
        if (b_q[i] !== frame_bit(64'hFFFF_FFFF_FFFF_FFFF, i)) bad++;
      end else if (b_q[i] !== frame_bit(64'h0, i - FRAME_LEN)) begin
        bad++;
      end
    end
    check("b2b_bits", 65'(bad), 65'(0));
    check("b2b_done_count", 65'(done_idx.size()), 65'(2));
    if (done_idx.size() == 2) begin
      check("b2b_done_first", 65'(done_idx[0]), 65'(FRAME_LEN - 1));
      check("b2b_done_gap", 65'(done_idx[1] - done_idx[0]), 65'(FRAME_LEN));
    end

    // reset in the middle of a frame
    start_frame(64'hA5A5_A5A5_A5A5_A5A5);
    for (int k = 0; k < 100 && cap_len < 20; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_frame", 65'(frame_out), 65'(0));
    check("midrst_data", 65'(data_out), 65'(0));
    check("midrst_ready", 65'(blk_ready), 65'(1));
    for (int k = 0; k < 3; k++) step();
    check("midrst_idle_frame", 65'(frame_out), 65'(0));
    rv = '{64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b0};
    run_vec(rv, "after_rst");

    // random frames with random gaps and ignored valid pulses
    for (int n = 0; n < 20; n++) begin
      for (int g = $urandom_range(0, 4); g > 0; g--) step();
      rb = {$urandom, $urandom};
      rv = '{rb, rb, par_of(rb), 1'b1};
      run_vec(rv, $sformatf("rand%0d", n));
    end
    for (int k = 0; k < 5; k++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
